// File: rtl/patch_frame_serializer.sv
// Double-buffered serializer: captures 4x4 patch frames, streams one node per beat.
// Optional PATCH_MAXABS_EN adds out_maxabs (running max |value| of the current frame).
module patch_frame_serializer #(
  parameter int DATA_W  = 18,
  parameter int FRAME_W = 16,
  parameter int DROP_W  = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [3:0][3:0][DATA_W-1:0] u_2_mid,
  input  logic                           iter_flag,
  output logic signed [DATA_W-1:0]       out_data,
  output logic [1:0]                     out_row,
  output logic [1:0]                     out_col,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic [FRAME_W-1:0]             frame_count,
  output logic [DROP_W-1:0]              drop_count
`ifdef PATCH_MAXABS_EN
  ,
  output logic [DATA_W-2:0]              out_maxabs
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0][DATA_W-1:0] w_frame;
  logic [15:0][DATA_W-1:0] r_active;
  logic [15:0][DATA_W-1:0] r_pending;
  logic                    r_pend_full;
  logic                    r_flag_d;
  logic                    r_cap_ev;
  logic [3:0]              r_idx;
  logic [FRAME_W-1:0]      r_frame_cnt;
  logic [DROP_W-1:0]       r_drop_cnt;

  logic w_rise;
  logic w_xfer;
  logic w_last_xfer;

  // Row-major flatten: element [r][c] lands at index 4*r+c.
  assign w_frame     = u_2_mid;
  assign w_rise      = iter_flag & ~r_flag_d;
  assign w_xfer      = out_valid & out_ready;
  assign w_last_xfer = w_xfer & (r_idx == 4'd15);

  assign frame_count = r_frame_cnt;
  assign drop_count  = r_drop_cnt;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_cap_ev) w_next = S_SEND;
      end
      S_SEND: begin
        if (w_last_xfer && !r_pend_full && !r_cap_ev)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beat outputs are driven from the active buffer only while sending.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = 2'd0;
    out_col   = 2'd0;
    out_last  = 1'b0;
    busy      = r_pend_full;
    if (r_state == S_SEND) begin
      out_valid = 1'b1;
      out_data  = $signed(r_active[r_idx]);
      out_row   = r_idx[3:2];
      out_col   = r_idx[1:0];
      out_last  = (r_idx == 4'd15);
      busy      = 1'b1;
    end
  end

  // Flag edge detect; capture is delayed one cycle so the patch can settle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_flag_d <= 1'b0;
      r_cap_ev <= 1'b0;
    end else begin
      r_flag_d <= iter_flag;
      r_cap_ev <= w_rise;
    end
  end

  // Buffer, beat index and counter datapath.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_idx       <= 4'd0;
      r_pend_full <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (r_cap_ev) begin
          r_active <= w_frame;
          r_idx    <= 4'd0;
        end
      end else begin
        if (w_xfer) r_idx <= r_idx + 4'd1;
        if (w_last_xfer) begin
          r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
          if (r_pend_full) begin
            r_active    <= r_pending;
            r_pend_full <= r_cap_ev;
            if (r_cap_ev) r_pending <= w_frame;
          end else if (r_cap_ev) begin
            r_active <= w_frame;
          end
        end else if (r_cap_ev) begin
          if (!r_pend_full) begin
            r_pending   <= w_frame;
            r_pend_full <= 1'b1;
          end else if (r_drop_cnt != {DROP_W{1'b1}}) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
          end
        end
      end
    end
  end

`ifdef PATCH_MAXABS_EN
  logic [DATA_W-2:0] r_maxabs;
  logic [DATA_W-2:0] w_abs;
  logic              w_load_active;

  // Magnitude with the most-negative value clamped to the largest positive.
  function automatic logic [DATA_W-2:0] f_abs(input logic [DATA_W-1:0] v);
    if (!v[DATA_W-1]) return v[DATA_W-2:0];
    if (v[DATA_W-2:0] == '0) return '1;
    return (~v[DATA_W-2:0]) + (DATA_W-1)'(1);
  endfunction

  assign w_abs = f_abs(out_data);
  assign w_load_active =
    ((r_state == S_IDLE) & r_cap_ev) |
    (w_last_xfer & (r_pend_full | r_cap_ev));

  // Running max clears on each new active frame, grows on each transfer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_maxabs <= '0;
    end else if (w_load_active) begin
      r_maxabs <= '0;
    end else if (w_xfer && (w_abs > r_maxabs)) begin
      r_maxabs <= w_abs;
    end
  end

  // Include the present beat in the reported max.
  always_comb begin
    out_maxabs = r_maxabs;
    if (w_abs > r_maxabs) out_maxabs = w_abs;
  end
`endif

endmodule

// File: tb/tb_patch_frame_serializer.sv
// Directed bench for patch_frame_serializer.
// Covers latency, stalls, double buffering, drops, held flag, reset, maxabs.
module tb_patch_frame_serializer;

  localparam int DATA_W  = 18;
  localparam int FRAME_W = 16;
  localparam int DROP_W  = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic signed [3:0][3:0][DATA_W-1:0] u_2_mid = '0;
  logic iter_flag = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DATA_W-1:0] out_data;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic out_valid;
  logic out_last;
  logic busy;
  logic [FRAME_W-1:0] frame_count;
  logic [DROP_W-1:0] drop_count;
`ifdef PATCH_MAXABS_EN
  logic [DATA_W-2:0] out_maxabs;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  patch_frame_serializer #(
    .DATA_W(DATA_W), .FRAME_W(FRAME_W), .DROP_W(DROP_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .u_2_mid(u_2_mid),
    .iter_flag(iter_flag),
    .out_data(out_data),
    .out_row(out_row),
    .out_col(out_col),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .frame_count(frame_count),
    .drop_count(drop_count)
`ifdef PATCH_MAXABS_EN
    ,
    .out_maxabs(out_maxabs)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    iter_flag = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_u(input int base, input int rmul);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u_2_mid[r][c] = DATA_W'(base + rmul * r + c);
  endtask

  function automatic int exp_val(input int base, input int rmul, input int k);
    return base + rmul * (k / 4) + (k % 4);
  endfunction

  task automatic pulse();
    iter_flag = 1'b1;
    tick();
    iter_flag = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(out_valid), 1);
  endtask

  task automatic stream(input string tag, input int base, input int rmul);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_data"}, int'(out_data), exp_val(base, rmul, k));
      check({tag, "_rc"}, int'({out_row, out_col}), k);
      check({tag, "_last"}, int'(out_last), int'(k == 15));
      tick();
    end
  endtask

  initial begin
    // Reset state
    reset_dut();
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_frames", int'(frame_count), 0);
    check("rst_drops", int'(drop_count), 0);

    // Single frame, ready held high, latency check
    out_ready = 1'b1;
    set_u(0, 16);
    iter_flag = 1'b1;
    tick();
    check("lat_early", int'(out_valid), 0);
    iter_flag = 1'b0;
    tick();
    check("lat_valid", int'(out_valid), 1);
    stream("t1", 0, 16);
    check("t1_idle", int'(out_valid), 0);
    check("t1_frames", int'(frame_count), 1);
    check("t1_busy", int'(busy), 0);

    // Stalling consumer: ready pattern 1,0,0,1
    reset_dut();
    set_u(0, 16);
    pulse();
    wait_valid("t2_start", 5);
    begin
      int b = 0;
      int cyc = 0;
      while (b < 16 && cyc < 200) begin
        out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        check("t2_valid", int'(out_valid), 1);
        check("t2_data", int'(out_data), exp_val(0, 16, b));
        check("t2_rc", int'({out_row, out_col}), b);
        check("t2_last", int'(out_last), int'(b == 15));
        if (out_ready) b++;
        tick();
        cyc++;
      end
      check("t2_beats", b, 16);
    end
    out_ready = 1'b0;
    check("t2_idle", int'(out_valid), 0);
    check("t2_frames", int'(frame_count), 1);

    // A active, B pending, C dropped; then A,B back to back
    reset_dut();
    set_u(1000, 4);
    pulse();
    repeat (18) tick();
    set_u(2000, 4);
    pulse();
    repeat (18) tick();
    set_u(3000, 4);
    pulse();
    repeat (3) tick();
    check("t3_drops", int'(drop_count), 1);
    check("t3_busy", int'(busy), 1);
    check("t3_hold", int'(out_data), 1000);
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check("t3_valid", int'(out_valid), 1);
      check("t3_data", int'(out_data), k < 16 ? 1000 + k : 2000 + k - 16);
      check("t3_last", int'(out_last), int'(k == 15 || k == 31));
      tick();
    end
    check("t3_idle", int'(out_valid), 0);
    check("t3_frames", int'(frame_count), 2);
    check("t3_drops2", int'(drop_count), 1);

    // Flag held high for 10 cycles: exactly one frame
    reset_dut();
    out_ready = 1'b1;
    set_u(500, 4);
    iter_flag = 1'b1;
    begin
      int beats = 0;
      for (int i = 0; i < 60; i++) begin
        if (i == 10) iter_flag = 1'b0;
        if (out_valid && out_ready) beats++;
        tick();
      end
      check("t4_beats", beats, 16);
    end
    check("t4_frames", int'(frame_count), 1);
    check("t4_drops", int'(drop_count), 0);

    // New frame lands on the beat-15 transfer with pending empty
    reset_dut();
    out_ready = 1'b1;
    set_u(100, 4);
    pulse();
    for (int k = 0; k < 32; k++) begin
      if (k == 14) begin
        set_u(200, 4);
        iter_flag = 1'b1;
      end
      if (k == 15) iter_flag = 1'b0;
      check("t5_valid", int'(out_valid), 1);
      check("t5_data", int'(out_data), k < 16 ? 100 + k : 200 + k - 16);
      tick();
    end
    check("t5_idle", int'(out_valid), 0);
    check("t5_frames", int'(frame_count), 2);
    check("t5_drops", int'(drop_count), 0);

    // Reset at beat 7 with a pending frame held
    reset_dut();
    set_u(1000, 4);
    pulse();
    repeat (4) tick();
    set_u(2000, 4);
    pulse();
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (7) tick();
    check("t6_beat7", int'(out_data), 1007);
    check("t6_pend", int'(busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    check("t6_valid", int'(out_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_frames", int'(frame_count), 0);
    check("t6_drops", int'(drop_count), 0);
    set_u(4000, 4);
    pulse();
    stream("t6", 4000, 4);
    repeat (3) tick();
    check("t6_nopend", int'(out_valid), 0);
    check("t6_frames2", int'(frame_count), 1);

`ifdef PATCH_MAXABS_EN
    // Running max magnitude with the most-negative value saturating
    reset_dut();
    u_2_mid = '0;
    u_2_mid[0][0] = -18'sd131072;
    u_2_mid[1][2] = 18'sd5000;
    pulse();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("mx_sat", int'(out_maxabs), 131071);
      tick();
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u_2_mid[r][c] = 18'sd7;
    pulse();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("mx_seven", int'(out_maxabs), 7);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
